// File: rtl/sc_phase_sequencer.sv
// Two-phase non-overlapping clock sequencer for a switched-capacitor filter.
// Generates phi1/phi2 plus early-falling phi1e/phi2e; every output comes straight from a flop.
module sc_phase_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_phase,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [CNT_W-1:0] cfg_early,
    output logic             phi1,
    output logic             phi2,
    output logic             phi1e,
    output logic             phi2e,
    output logic             busy,
    output logic             cycle_done,
    output logic             cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_GAP1,
        S_P2,
        S_GAP2
    } state_t;

    localparam logic [CNT_W-1:0] DEF_N = CNT_W'(4);
    localparam logic [CNT_W-1:0] DEF_G = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_E = CNT_W'(1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pend_n, r_pend_g, r_pend_e;
    logic [CNT_W-1:0] r_act_n, r_act_g, r_act_e;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_e_sel;
    logic             w_load_act;
    logic             w_cnt_zero;
    logic             w_cfg_ok;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_cfg_ok   = (cfg_phase != '0) && (cfg_gap != '0) && (cfg_early < cfg_phase);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt - ONE;
        w_load_act  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = r_cnt;
                if (en) begin
                    w_state_nxt = S_P1;
                    w_cnt_nxt   = r_pend_n - ONE;
                    w_load_act  = 1'b1;
                end
            end
            S_P1: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_GAP1;
                    w_cnt_nxt   = r_act_g - ONE;
                end
            end
            S_GAP1: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_P2;
                    w_cnt_nxt   = r_act_n - ONE;
                end
            end
            S_P2: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_GAP2;
                    w_cnt_nxt   = r_act_g - ONE;
                end
            end
            S_GAP2: begin
                if (w_cnt_zero) begin
                    if (en) begin
                        w_state_nxt = S_P1;
                        w_cnt_nxt   = r_pend_n - ONE;
                        w_load_act  = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // The E threshold must come from the config that the next cycle will actually use
        w_e_sel = w_load_act ? r_pend_e : r_act_e;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_pend_n   <= DEF_N;
            r_pend_g   <= DEF_G;
            r_pend_e   <= DEF_E;
            r_act_n    <= DEF_N;
            r_act_g    <= DEF_G;
            r_act_e    <= DEF_E;
            cfg_err    <= 1'b0;
            phi1       <= 1'b0;
            phi2       <= 1'b0;
            phi1e      <= 1'b0;
            phi2e      <= 1'b0;
            busy       <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_load_act) begin
                r_act_n <= r_pend_n;
                r_act_g <= r_pend_g;
                r_act_e <= r_pend_e;
            end
            if (cfg_load) begin
                cfg_err <= !w_cfg_ok;
                if (w_cfg_ok) begin
                    r_pend_n <= cfg_phase;
                    r_pend_g <= cfg_gap;
                    r_pend_e <= cfg_early;
                end
            end
            // Outputs are registered from next-state so the switch gates see clean flop edges
            phi1       <= (w_state_nxt == S_P1);
            phi2       <= (w_state_nxt == S_P2);
            phi1e      <= (w_state_nxt == S_P1) && (w_cnt_nxt >= w_e_sel);
            phi2e      <= (w_state_nxt == S_P2) && (w_cnt_nxt >= w_e_sel);
            busy       <= (w_state_nxt != S_IDLE);
            cycle_done <= (w_state_nxt == S_GAP2) && (w_cnt_nxt == '0);
        end
    end

endmodule

// File: tb/tb_sc_phase_sequencer.sv
// Bench for sc_phase_sequencer: a period-position reference model checked every cycle,
// directed scenarios followed by randomized config/en/rst traffic.
module tb_sc_phase_sequencer;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             cfg_load = 1'b0;
    logic [CNT_W-1:0] cfg_phase = '0;
    logic [CNT_W-1:0] cfg_gap = '0;
    logic [CNT_W-1:0] cfg_early = '0;
    logic             phi1, phi2, phi1e, phi2e, busy, cycle_done, cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position within the current period plus the config it runs with
    int m_run = 0, m_pos = 0;
    int m_n = 4, m_g = 1, m_e = 1;
    int p_n = 4, p_g = 1, p_e = 1;
    int m_err = 0;

    sc_phase_sequencer #(.CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_load   (cfg_load),
        .cfg_phase  (cfg_phase),
        .cfg_gap    (cfg_gap),
        .cfg_early  (cfg_early),
        .phi1       (phi1),
        .phi2       (phi2),
        .phi1e      (phi1e),
        .phi2e      (phi2e),
        .busy       (busy),
        .cycle_done (cycle_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int period;
        if (rst) begin
            m_run = 0; m_pos = 0;
            m_n = 4; m_g = 1; m_e = 1;
            p_n = 4; p_g = 1; p_e = 1;
            m_err = 0;
            return;
        end
        period = 2 * (m_n + m_g);
        if (m_run != 0) begin
            if (m_pos == period - 1) begin
                if (en) begin
                    m_n = p_n; m_g = p_g; m_e = p_e; m_pos = 0;
                end else begin
                    m_run = 0; m_pos = 0;
                end
            end else begin
                m_pos++;
            end
        end else if (en) begin
            m_run = 1; m_pos = 0;
            m_n = p_n; m_g = p_g; m_e = p_e;
        end
        if (cfg_load) begin
            if (int'(cfg_phase) >= 1 && int'(cfg_gap) >= 1 && int'(cfg_early) < int'(cfg_phase)) begin
                p_n = int'(cfg_phase); p_g = int'(cfg_gap); p_e = int'(cfg_early);
                m_err = 0;
            end else begin
                m_err = 1;
            end
        end
    endtask

    function automatic logic [6:0] model_out();
        logic a1, a1e, a2, a2e, dn;
        int s2;
        a1 = 0; a1e = 0; a2 = 0; a2e = 0; dn = 0;
        if (m_run != 0) begin
            s2  = m_n + m_g;
            a1  = (m_pos < m_n);
            a1e = (m_pos < m_n - m_e);
            a2  = (m_pos >= s2) && (m_pos < s2 + m_n);
            a2e = (m_pos >= s2) && (m_pos < s2 + m_n - m_e);
            dn  = (m_pos == 2 * s2 - 1);
        end
        return {a1, a1e, a2, a2e, (m_run != 0), dn, (m_err != 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("outputs", {25'd0, phi1, phi1e, phi2, phi2e, busy, cycle_done, cfg_err},
                 {25'd0, model_out()});
        check_eq("no_overlap", {31'd0, phi1 & phi2}, 32'd0);
        check_eq("phie_subset", {31'd0, (phi1e & ~phi1) | (phi2e & ~phi2)}, 32'd0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_cfg(input int n, input int g, input int e);
        cfg_phase = CNT_W'(n); cfg_gap = CNT_W'(g); cfg_early = CNT_W'(e);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic wait_pos(input string tag, input int pos, input int budget);
        int k;
        k = 0;
        while (!(m_run != 0 && m_pos == pos) && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, {31'd0, (m_run != 0 && m_pos == pos)}, 32'd1);
    endtask

    initial begin
        // Reset, then defaults with en held high
        ticks(2);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        en  = 1'b1;
        ticks(30);

        // Stop, then a valid N=6 G=2 E=0 load while idle
        en = 1'b0;
        ticks(12);
        check_eq("idle_after_stop", {31'd0, busy}, 32'd0);
        load_cfg(6, 2, 0);
        check_eq("valid_load_err", {31'd0, cfg_err}, 32'd0);
        en = 1'b1;
        ticks(40);

        // Invalid load mid-run, then a valid one that takes effect at the next P1
        load_cfg(4, 0, 4);
        check_eq("invalid_load_err", {31'd0, cfg_err}, 32'd1);
        ticks(20);
        load_cfg(3, 1, 2);
        check_eq("recover_err", {31'd0, cfg_err}, 32'd0);
        ticks(40);

        // en dropped during the second cycle of P2
        wait_pos("wait_p2", m_n + m_g + 1, 100);
        en = 1'b0;
        ticks(20);
        check_eq("drain_busy", {31'd0, busy}, 32'd0);

        // rst in the third cycle of P1, restart with en high
        en = 1'b1;
        wait_pos("wait_p1", 2, 100);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_phi1", {31'd0, phi1}, 32'd0);
        rst = 1'b0;
        tick();
        check_eq("restart_phi1", {31'd0, phi1}, 32'd1);
        ticks(15);

        // Maximum field values
        load_cfg(255, 255, 254);
        ticks(2100);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 10000; c++) begin
            int nn;
            en  = ($urandom_range(0, 99) < 85);
            rst = ($urandom_range(0, 999) == 0);
            cfg_load = ($urandom_range(0, 99) < 5);
            nn = $urandom_range(1, 8);
            cfg_phase = CNT_W'(nn);
            cfg_gap   = CNT_W'($urandom_range(0, 4));
            cfg_early = CNT_W'($urandom_range(0, nn));
            tick();
        end
        rst = 1'b0;
        cfg_load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
